program_sequencer: RTL and testbench
====================================

# program_sequencer

Synthesizable program store and run controller for the single-cycle ARM-subset processor. It accepts a program as a stream of 32-bit words and holds the processor in reset while loading. It then releases the processor and serves `instruction` from the processor's `pc`. Execution stops on a halt word, an out-of-range fetch or, optionally, a watchdog timeout. It replaces hand-driven instruction sequencing at the processor boundary, both on the bench and in the FPGA top level.

## Interface
- `DATA_W`, 32: instruction width.
- `ADDR_W`, 8: width of processor `pc` (byte address).
- `DEPTH`, 64: program words; must satisfy DEPTH ≤ 2^(ADDR_W-2) and DEPTH ≥ 2.
- `HALT_WORD`, 32'h0000_0000: instruction value that ends a run.
- `MAX_CYCLES`, 1024: watchdog limit (only with `PSEQ_WATCHDOG_EN`).

Ports:
- `clk`, in, 1: single clock; everything is updated on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `clear`, in, 1: synchronous program discard.
- `load_valid`, in, 1: load word present.
- `load_ready`, out, 1: block can accept a word.
- `load_data`, in, DATA_W: program word.
- `load_last`, in, 1: marks the final program word.
- `start`, in, 1: run request.
- `pc`, in, ADDR_W: processor program counter.
- `instruction`, out, DATA_W: word fed to the processor.
- `cpu_rst`, out, 1: processor reset.
- `running`, out, 1: high while state is RUN.
- `done`, out, 1: high while state is DONE.
- `err`, out, 1: run ended abnormally; valid while `done` is high.
- `prog_len`, out, ADDR_W-1: number of words loaded.
- `cycle_count`, out, 16: cycles spent in RUN, saturating.

## Operation
- States: IDLE, LOAD, READY, RUN, DONE.
- Reset state: IDLE with `prog_len`=0, `cycle_count`=0, `err`=0, `load_ready`=1, `cpu_rst`=1, `instruction`=0, `running`=0, `done`=0.
- `cpu_rst` = (state != RUN).
- `load_ready` = state ∈ {IDLE, LOAD}.
- Load handshake (IDLE/LOAD, `load_valid` & `load_ready`):
  - `mem[prog_len]` ← `load_data`, `prog_len`++, and the state becomes LOAD.
  - If `load_last` is high, or the accepted word is at index DEPTH-1, the state becomes READY. The full condition does not depend on `load_last`.
- Start:
  - READY + `start` → RUN with `cycle_count` cleared.
  - DONE + `start` → RUN (re-run) with `cycle_count` and `err` cleared.
  - `start` is ignored in IDLE, LOAD and RUN.
- Fetch in RUN, combinational:
  - Word index is `pc[ADDR_W-1:2]`; `pc[1:0]` is ignored.
  - If index < `prog_len`, `instruction` = `mem[index]`; otherwise `instruction` = 0.
  - In all other states `instruction` = 0.
- Run termination, evaluated each RUN cycle; the state becomes DONE at the next edge:
  - Fetched word == HALT_WORD → `err`=0.
  - Index ≥ `prog_len` → `err`=1.
  - If both conditions hold, `err`=1.
- `cycle_count` increments every RUN cycle, including the terminating one, and saturates at 16'hFFFF.
- `clear` in any state → IDLE with `prog_len`=0 and `err`=0. Memory contents are not erased.
- Simultaneous events:
  - `rst` beats everything.
  - `clear` beats `start` and load handshakes.
  - `clear` during RUN aborts the run; `cpu_rst` rises at the next edge.

## Timing
- Load: one word per cycle with no bubbles.
- READY→RUN: one edge after `start`. `cpu_rst` falls in that same cycle, so the processor's first execute cycle fetches pc=0.
- Fetch: zero-cycle combinational path from `pc` to `instruction`.
- Termination: `done` rises one edge after the halt or out-of-range fetch. `cpu_rst` rises at that same edge, so the processor does not execute the halt word's successor.
- All status outputs are registered or derived directly from registered state.

## Configuration
- `PSEQ_WATCHDOG_EN` defined:
  - If `cycle_count` reaches MAX_CYCLES while in RUN, the state becomes DONE with `err`=1 at that edge.
  - Halt and out-of-range conditions keep priority on the same cycle.
- `PSEQ_WATCHDOG_EN` undefined: no watchdog logic is built, and MAX_CYCLES is unused.

## Test plan
- Reset with `rst`=1 for one edge → `cpu_rst`=1, `load_ready`=1, `instruction`=0, `prog_len`=0, `done`=0.
- Load 7 words (e3a00002, e2800002, e3a01002, e3a02003, e0813002, e1530000, 00000000), with `load_last` on the seventh → `prog_len`=7, state READY. Pulse `start` and drive `pc`=0,4,…,24 → `instruction` follows the loaded words. `done`=1 and `err`=0 one edge after pc=24; `cycle_count`=7.
- Load 3 words with no zero word, start, and drive `pc`=12 → `instruction`=0 and `done`=1 with `err`=1 one edge later.
- Load DEPTH words with `load_last` held 0 → READY after the DEPTH-th word; `load_ready`=0; a further `load_valid` is ignored and `prog_len` stays DEPTH.
- Assert `clear` and `start` together in READY → IDLE, `prog_len`=0, `cpu_rst`=1. Then start from DONE on a stored program → a re-run with `cycle_count` restarting at 0.
- With `PSEQ_WATCHDOG_EN` and MAX_CYCLES=16, hold `pc`=0 on a non-halt word → DONE with `err`=1 and `cycle_count`=16.

Source files
------------

// File: rtl/program_sequencer.sv
// program_sequencer: program store and run controller for the ARM-subset core.
// Loads a word stream, releases the core and serves instruction from pc.
// Ports:
//   clk, rst (sync, active high), clear (sync program discard)
//   load_valid/load_ready/load_data/load_last: program word stream
//   start: run request; pc: core byte address; instruction: fetched word
//   cpu_rst, running, done, err, prog_len, cycle_count: status
// Build option: define PSEQ_WATCHDOG_EN to end runs after MAX_CYCLES cycles.
module program_sequencer #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 8,
  parameter int                DEPTH      = 64,
  parameter logic [DATA_W-1:0] HALT_WORD  = '0,
  parameter int                MAX_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instruction,
  output logic              cpu_rst,
  output logic              running,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-2:0] prog_len,
  output logic [15:0]       cycle_count
);

  localparam int PLW = ADDR_W - 1;
  localparam int IW  = ADDR_W - 2;

  if (DEPTH < 2 || DEPTH > (1 << IW) || MAX_CYCLES < 1) begin : g_cfg_err
    $error("program_sequencer: illegal DEPTH/ADDR_W/MAX_CYCLES");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READY,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PLW-1:0]    r_prog_len;
  logic              r_err;
  logic [15:0]       r_cycles;

  logic [IW-1:0]     w_idx;
  logic              w_oob;
  logic [DATA_W-1:0] w_rd;
  logic [DATA_W-1:0] w_fetch;
  logic              w_halt;
  logic              w_load_fire;
  logic              w_full;
  logic [15:0]       w_cyc_nxt;
  logic              w_wdog;
  logic              w_unused;

  // pc is a byte address; the core only ever fetches whole words
  assign w_idx    = pc[ADDR_W-1:2];
  assign w_unused = ^pc[1:0];

  assign w_oob   = {1'b0, w_idx} >= r_prog_len;
  assign w_rd    = r_mem[w_idx];
  assign w_fetch = (r_state == S_RUN && !w_oob) ? w_rd : '0;
  assign w_halt  = (w_fetch == HALT_WORD);

  assign w_load_fire = load_valid && load_ready;
  // Full is judged on the index being written, independent of load_last
  assign w_full      = (r_prog_len == PLW'(DEPTH - 1));

  assign w_cyc_nxt = (r_cycles == 16'hFFFF) ? r_cycles
                                            : r_cycles + 16'd1;

`ifdef PSEQ_WATCHDOG_EN
  assign w_wdog = (32'(w_cyc_nxt) >= 32'(MAX_CYCLES));
`else
  assign w_wdog = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst && !clear && w_load_fire) begin
      r_mem[r_prog_len[IW-1:0]] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_prog_len <= '0;
      r_err      <= 1'b0;
      r_cycles   <= '0;
    end else if (clear) begin
      r_state    <= S_IDLE;
      r_prog_len <= '0;
      r_err      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_LOAD: begin
          if (load_valid) begin
            r_prog_len <= r_prog_len + 1'b1;
            r_state    <= (load_last || w_full) ? S_READY : S_LOAD;
          end
        end
        S_READY: begin
          if (start) begin
            r_state  <= S_RUN;
            r_cycles <= '0;
          end
        end
        S_RUN: begin
          r_cycles <= w_cyc_nxt;
          // out-of-range wins over halt; watchdog is lowest
          if (w_oob) begin
            r_state <= S_DONE;
            r_err   <= 1'b1;
          end else if (w_halt) begin
            r_state <= S_DONE;
            r_err   <= 1'b0;
          end else if (w_wdog) begin
            r_state <= S_DONE;
            r_err   <= 1'b1;
          end
        end
        S_DONE: begin
          if (start) begin
            r_state  <= S_RUN;
            r_cycles <= '0;
            r_err    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign load_ready  = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign cpu_rst     = (r_state != S_RUN);
  assign running     = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign err         = r_err;
  assign prog_len    = r_prog_len;
  assign cycle_count = r_cycles;
  assign instruction = w_fetch;

endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: scoreboard bench for program_sequencer.
// Stimulus queues expectations; monitors compare on the falling edge.
module tb_program_sequencer;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;
  logic        start;
  logic [7:0]  pc;
  logic [31:0] instruction;
  logic        cpu_rst;
  logic        running;
  logic        done;
  logic        err;
  logic [6:0]  prog_len;
  logic [15:0] cycle_count;

  program_sequencer #(
    .DATA_W    (32),
    .ADDR_W    (8),
    .DEPTH     (DEPTH),
    .HALT_WORD (32'h0000_0000),
    .MAX_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .start      (start),
    .pc         (pc),
    .instruction(instruction),
    .cpu_rst    (cpu_rst),
    .running    (running),
    .done       (done),
    .err        (err),
    .prog_len   (prog_len),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  localparam int SEL_INSTR = 0;
  localparam int SEL_CRST  = 1;
  localparam int SEL_LRDY  = 2;
  localparam int SEL_PLEN  = 3;
  localparam int SEL_DONE  = 4;
  localparam int SEL_ERR   = 5;
  localparam int SEL_RUN   = 6;
  localparam int SEL_CYC   = 7;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  typedef struct {
    string       name;
    logic        err;
    logic [15:0] cyc;
  } run_t;

  chk_t        chkq [$];
  run_t        runq [$];
  logic [31:0] prog [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  chk_t        m_it;
  run_t        m_run;
  logic [31:0] m_act;
  logic        m_done_q = 1'b0;

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      SEL_INSTR: return instruction;
      SEL_CRST:  return {31'd0, cpu_rst};
      SEL_LRDY:  return {31'd0, load_ready};
      SEL_PLEN:  return {25'd0, prog_len};
      SEL_DONE:  return {31'd0, done};
      SEL_ERR:   return {31'd0, err};
      SEL_RUN:   return {31'd0, running};
      default:   return {16'd0, cycle_count};
    endcase
  endfunction

  always @(negedge clk) begin
    while (chkq.size() > 0) begin
      m_it  = chkq.pop_front();
      m_act = probe(m_it.sel);
      n_checks++;
      if (m_act !== m_it.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", m_it.name, m_act, m_it.exp);
      end
    end
    if (done && !m_done_q) begin
      if (runq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no run end");
      end else begin
        m_run = runq.pop_front();
        n_checks += 2;
        if (err !== m_run.err) begin
          n_fail++;
          $display("FAIL %s_err: got %b expected %b", m_run.name, err, m_run.err);
        end
        if (cycle_count !== m_run.cyc) begin
          n_fail++;
          $display("FAIL %s_cycles: got %0d expected %0d",
                   m_run.name, cycle_count, m_run.cyc);
        end
      end
    end
    m_done_q = done;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int sel, input logic [31:0] exp);
    chk_t it;
    it.name = name;
    it.sel  = sel;
    it.exp  = exp;
    chkq.push_back(it);
  endtask

  task automatic expect_run(input string name, input logic e, input logic [15:0] c);
    run_t r;
    r.name = name;
    r.err  = e;
    r.cyc  = c;
    runq.push_back(r);
  endtask

  task automatic load_range(input int from, input int to, input bit use_last);
    for (int i = from; i < to; i++) begin
      load_valid = 1'b1;
      load_data  = prog[i];
      load_last  = use_last && (i == to - 1);
      step();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no end of test expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    clear      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    start      = 1'b0;
    pc         = '0;
    step();
    rst = 1'b0;
    chk("rst_cpu_rst", SEL_CRST, 1);
    chk("rst_load_ready", SEL_LRDY, 1);
    chk("rst_instr", SEL_INSTR, 0);
    chk("rst_prog_len", SEL_PLEN, 0);
    chk("rst_done", SEL_DONE, 0);
    chk("rst_err", SEL_ERR, 0);
    chk("rst_running", SEL_RUN, 0);
    chk("rst_cycles", SEL_CYC, 0);

    // 7-word program ending in a halt word
    prog[0] = 32'he3a00002;
    prog[1] = 32'he2800002;
    prog[2] = 32'he3a01002;
    prog[3] = 32'he3a02003;
    prog[4] = 32'he0813002;
    prog[5] = 32'he1530000;
    prog[6] = 32'h00000000;
    load_range(0, 7, 1'b1);
    chk("p1_prog_len", SEL_PLEN, 7);
    chk("p1_ready_no_load", SEL_LRDY, 0);
    chk("p1_ready_cpu_rst", SEL_CRST, 1);
    chk("p1_ready_instr", SEL_INSTR, 0);
    expect_run("p1", 1'b0, 16'd7);
    pc = 8'd0;
    pulse_start();
    chk("p1_run_cpu_rst", SEL_CRST, 0);
    chk("p1_run_cycles0", SEL_CYC, 0);
    for (int k = 0; k < 7; k++) begin
      pc = 8'(4 * k);
      chk($sformatf("p1_instr%0d", k), SEL_INSTR, prog[k]);
      step();
    end
    chk("p1_done", SEL_DONE, 1);
    chk("p1_cpu_rst_back", SEL_CRST, 1);
    chk("p1_done_instr0", SEL_INSTR, 0);

    // out-of-range fetch
    do_clear();
    chk("clr_prog_len", SEL_PLEN, 0);
    chk("clr_done", SEL_DONE, 0);
    chk("clr_err", SEL_ERR, 0);
    prog[0] = 32'h11111111;
    prog[1] = 32'h22222222;
    prog[2] = 32'h33333333;
    load_range(0, 3, 1'b1);
    chk("p2_prog_len", SEL_PLEN, 3);
    expect_run("p2_oob", 1'b1, 16'd1);
    pc = 8'd0;
    pulse_start();
    pc = 8'd12;
    chk("p2_oob_instr", SEL_INSTR, 0);
    step();
    chk("p2_done", SEL_DONE, 1);
    chk("p2_err", SEL_ERR, 1);

    // full program without load_last
    do_clear();
    for (int i = 0; i < DEPTH; i++) prog[i] = 32'hA500_0000 + 32'(i);
    load_range(0, DEPTH - 1, 1'b0);
    chk("p3_not_full_ready", SEL_LRDY, 1);
    chk("p3_len63", SEL_PLEN, DEPTH - 1);
    load_range(DEPTH - 1, DEPTH, 1'b0);
    chk("p3_full_len", SEL_PLEN, DEPTH);
    chk("p3_full_no_load", SEL_LRDY, 0);
    load_valid = 1'b1;
    load_data  = 32'hDEADBEEF;
    load_last  = 1'b1;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("p3_extra_ignored", SEL_PLEN, DEPTH);
    chk("p3_still_ready", SEL_RUN, 0);

    // clear beats start; start ignored in IDLE
    clear = 1'b1;
    start = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    chk("p4_clr_running", SEL_RUN, 0);
    chk("p4_clr_cpu_rst", SEL_CRST, 1);
    chk("p4_clr_prog_len", SEL_PLEN, 0);
    chk("p4_clr_load_ready", SEL_LRDY, 1);
    pulse_start();
    chk("p4_idle_start_ignored", SEL_RUN, 0);

    // run, then re-run from DONE; pc low bits are ignored
    prog[0] = 32'he3a00002;
    prog[1] = 32'he2800002;
    prog[2] = 32'h00000000;
    load_range(0, 3, 1'b1);
    expect_run("p4a", 1'b0, 16'd3);
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      pc = 8'(4 * k + (k + 1) % 4);
      chk($sformatf("p4a_instr%0d", k), SEL_INSTR, prog[k]);
      step();
    end
    chk("p4a_done", SEL_DONE, 1);
    expect_run("p4b", 1'b0, 16'd3);
    pulse_start();
    chk("p4b_rerun_cycles0", SEL_CYC, 0);
    chk("p4b_rerun_running", SEL_RUN, 1);
    chk("p4b_rerun_done", SEL_DONE, 0);
    for (int k = 0; k < 3; k++) begin
      pc = 8'(4 * k);
      start = (k == 1);
      chk($sformatf("p4b_instr%0d", k), SEL_INSTR, prog[k]);
      step();
    end
    start = 1'b0;
    chk("p4b_done", SEL_DONE, 1);

    // clear aborts a run
    pc = 8'd0;
    pulse_start();
    step();
    chk("p4c_mid_run", SEL_CRST, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("p4c_abort_cpu_rst", SEL_CRST, 1);
    chk("p4c_abort_running", SEL_RUN, 0);
    chk("p4c_abort_prog_len", SEL_PLEN, 0);

    // no halt word: watchdog or endless run
    prog[0] = 32'he3a01002;
    prog[1] = 32'he1530000;
    load_range(0, 2, 1'b1);
    pc = 8'd0;
`ifdef PSEQ_WATCHDOG_EN
    expect_run("p5_wdog", 1'b1, 16'd16);
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("p5_instr%0d", k), SEL_INSTR, prog[0]);
      step();
    end
    chk("p5_wdog_done", SEL_DONE, 1);
    chk("p5_wdog_err", SEL_ERR, 1);
    chk("p5_wdog_cycles", SEL_CYC, 16);
`else
    pulse_start();
    for (int k = 0; k < 20; k++) step();
    chk("p5_still_running", SEL_RUN, 1);
    chk("p5_cycles", SEL_CYC, 20);
    chk("p5_no_done", SEL_DONE, 0);
`endif
    do_clear();
    step();
    step();
    n_checks++;
    if (runq.size() != 0) begin
      n_fail++;
      $display("FAIL run_queue_drain: got %0d pending expected 0", runq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
